// File: rtl/sap1_if.sv
// Control-sequencer bus for the SAP-1 controller: instruction/run inputs in,
// ring state and the twelve-signal control word out.
interface sap1_if;
  logic [3:0] opcode;
  logic       run;
  logic       step;
  logic [5:0] t_state;
  logic       cp;
  logic       ep;
  logic       lm_n;
  logic       ce_n;
  logic       li_n;
  logic       ei_n;
  logic       la_n;
  logic       ea;
  logic       su;
  logic       eu;
  logic       lb_n;
  logic       lo_n;
  logic       hlt;
  logic       instr_done;

  // master = the controller; slave = the datapath / IR side that feeds it
  modport master (
    input  opcode, run, step,
    output t_state, cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu,
           lb_n, lo_n, hlt, instr_done
  );

  modport slave (
    output opcode, run, step,
    input  t_state, cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu,
           lb_n, lo_n, hlt, instr_done
  );
endinterface

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: six-state one-hot ring with free-run or
// single-step advance, combinational control-word decode and a sticky halt.
module sap1_controller (
  input  logic   clk,
  input  logic   rst,
  sap1_if.master bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm_n;
    logic ce_n;
    logic li_n;
    logic ei_n;
    logic la_n;
    logic ea;
    logic su;
    logic eu;
    logic lb_n;
    logic lo_n;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    cp: 1'b0, ep: 1'b0, lm_n: 1'b1, ce_n: 1'b1, li_n: 1'b1, ei_n: 1'b1,
    la_n: 1'b1, ea: 1'b0, su: 1'b0, eu: 1'b0, lb_n: 1'b1, lo_n: 1'b1
  };

  t_state_e ring;
  logic     halted;
  logic     step_q;
  logic     done_q;
  logic     step_rise;
  logic     adv;
  ctrl_t    cw;

  assign step_rise = bus.step & ~step_q;
  assign adv       = ~halted & (bus.run | step_rise);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; the combinational decode below uses blocking (=).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring   <= T1;
      halted <= 1'b0;
      step_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      step_q <= bus.step;
      done_q <= adv && (ring == T6);
      if (adv) begin
        case (ring)
          T1: ring <= T2;
          T2: ring <= T3;
          T3: ring <= T4;
          T4: begin
            ring <= T5;
            if (bus.opcode == OP_HLT) halted <= 1'b1;
          end
          T5: ring <= T6;
          default: ring <= T1;
        endcase
      end
    end
  end

  // NOTE: cw gets its idle value first so every path assigns it and no latch
  // is inferred for the states/opcodes that drive nothing.
  always_comb begin
    cw = CTRL_IDLE;
    // rst gates the word directly so an abort silences the bus mid-cycle
    if (!rst && !halted) begin
      case (ring)
        T1: begin
          cw.ep   = 1'b1;
          cw.lm_n = 1'b0;
        end
        T2: cw.cp = 1'b1;
        T3: begin
          cw.ce_n = 1'b0;
          cw.li_n = 1'b0;
        end
        T4: begin
          if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            cw.ei_n = 1'b0;
            cw.lm_n = 1'b0;
          end else if (bus.opcode == OP_OUT) begin
            cw.ea   = 1'b1;
            cw.lo_n = 1'b0;
          end
        end
        T5: begin
          if (bus.opcode == OP_LDA) begin
            cw.ce_n = 1'b0;
            cw.la_n = 1'b0;
          end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            cw.ce_n = 1'b0;
            cw.lb_n = 1'b0;
          end
        end
        T6: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            cw.eu   = 1'b1;
            cw.su   = (bus.opcode == OP_SUB);
            cw.la_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.t_state    = ring;
  assign bus.hlt        = halted;
  assign bus.instr_done = done_q;
  assign bus.cp         = cw.cp;
  assign bus.ep         = cw.ep;
  assign bus.lm_n       = cw.lm_n;
  assign bus.ce_n       = cw.ce_n;
  assign bus.li_n       = cw.li_n;
  assign bus.ei_n       = cw.ei_n;
  assign bus.la_n       = cw.la_n;
  assign bus.ea         = cw.ea;
  assign bus.su         = cw.su;
  assign bus.eu         = cw.eu;
  assign bus.lb_n       = cw.lb_n;
  assign bus.lo_n       = cw.lo_n;

endmodule

// File: tb/tb_sap1_controller.sv
// Directed bench for sap1_controller: fetch/execute words per opcode, pause,
// single-step edge detection, halt freeze and asynchronous abort.
module tb_sap1_controller;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  sap1_if bus ();

  sap1_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // control word order: cp ep lm_n ce_n li_n ei_n la_n ea su eu lb_n lo_n
  localparam logic [11:0] W_IDLE  = 12'b001111100011;
  localparam logic [11:0] W_T1    = 12'b010111100011;
  localparam logic [11:0] W_T2    = 12'b101111100011;
  localparam logic [11:0] W_T3    = 12'b001001100011;
  localparam logic [11:0] W_T4MEM = 12'b000110100011;
  localparam logic [11:0] W_T4OUT = 12'b001111110010;
  localparam logic [11:0] W_T5LDA = 12'b001011000011;
  localparam logic [11:0] W_T5AB  = 12'b001011100001;
  localparam logic [11:0] W_T6ADD = 12'b001111000111;
  localparam logic [11:0] W_T6SUB = 12'b001111001111;

  localparam logic [3:0] LDA = 4'b0000;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] OUT = 4'b1110;
  localparam logic [3:0] HLT = 4'b1111;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [5:0] t, input logic [11:0] w,
                       input logic h, input logic d);
    logic [19:0] obs;
    logic [19:0] exp;
    obs = {bus.t_state, bus.cp, bus.ep, bus.lm_n, bus.ce_n, bus.li_n, bus.ei_n,
           bus.la_n, bus.ea, bus.su, bus.eu, bus.lb_n, bus.lo_n, bus.hlt, bus.instr_done};
    exp = {t, w, h, d};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed t=%b cw=%b hlt=%b done=%b, expected t=%b cw=%b hlt=%b done=%b",
             tag, obs[19:14], obs[13:2], obs[1], obs[0], t, w, h, d);
    end
  endtask

  // one full instruction in free-run, starting from T1
  task automatic run_instr(input logic [3:0] op, input string tag,
                           input logic [11:0] w4, input logic [11:0] w5, input logic [11:0] w6);
    bus.opcode = op;
    tick(); check({tag, "/T2"}, 6'b000010, W_T2, 1'b0, 1'b0);
    tick(); check({tag, "/T3"}, 6'b000100, W_T3, 1'b0, 1'b0);
    tick(); check({tag, "/T4"}, 6'b001000, w4,   1'b0, 1'b0);
    tick(); check({tag, "/T5"}, 6'b010000, w5,   1'b0, 1'b0);
    tick(); check({tag, "/T6"}, 6'b100000, w6,   1'b0, 1'b0);
    tick(); check({tag, "/T1"}, 6'b000001, W_T1, 1'b0, 1'b1);
  endtask

  initial begin
    rst        = 1'b1;
    bus.run    = 1'b0;
    bus.step   = 1'b0;
    bus.opcode = LDA;
    #3;
    check("reset_hold", 6'b000001, W_IDLE, 1'b0, 1'b0);
    #5 rst = 1'b0;
    tick(); check("idle_t1", 6'b000001, W_T1, 1'b0, 1'b0);

    // free-run instruction sequences
    bus.run = 1'b1;
    run_instr(LDA, "lda", W_T4MEM, W_T5LDA, W_IDLE);
    run_instr(ADD, "add", W_T4MEM, W_T5AB,  W_T6ADD);
    run_instr(SUB, "sub", W_T4MEM, W_T5AB,  W_T6SUB);
    run_instr(OUT, "out", W_T4OUT, W_IDLE,  W_IDLE);
    run_instr(4'b0111, "nop", W_IDLE, W_IDLE, W_IDLE);

    // run drops mid-instruction: ring stops at T5 with its word still driven
    bus.opcode = ADD;
    tick(); check("pause/T2", 6'b000010, W_T2,    1'b0, 1'b0);
    tick(); check("pause/T3", 6'b000100, W_T3,    1'b0, 1'b0);
    tick(); check("pause/T4", 6'b001000, W_T4MEM, 1'b0, 1'b0);
    tick(); check("pause/T5", 6'b010000, W_T5AB,  1'b0, 1'b0);
    bus.run = 1'b0;
    tick(); check("pause/hold1", 6'b010000, W_T5AB, 1'b0, 1'b0);
    tick(); check("pause/hold2", 6'b010000, W_T5AB, 1'b0, 1'b0);
    bus.run = 1'b1;
    tick(); check("pause/T6", 6'b100000, W_T6ADD, 1'b0, 1'b0);
    tick(); check("pause/T1", 6'b000001, W_T1,    1'b0, 1'b1);

    // single-step: a held step advances once, a fresh edge advances again
    bus.run    = 1'b0;
    bus.opcode = LDA;
    bus.step   = 1'b1;
    tick(); check("step/first", 6'b000010, W_T2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); check("step/held", 6'b000010, W_T2, 1'b0, 1'b0);
    end
    bus.step = 1'b0;
    tick(); check("step/low", 6'b000010, W_T2, 1'b0, 1'b0);
    bus.step = 1'b1;
    tick(); check("step/second", 6'b000100, W_T3, 1'b0, 1'b0);
    bus.step = 1'b0;
    tick(); check("step/settle", 6'b000100, W_T3, 1'b0, 1'b0);

    // run plus step edges: still one advance per edge
    bus.run  = 1'b1;
    bus.step = 1'b1;
    tick(); check("runstep/T4", 6'b001000, W_T4MEM, 1'b0, 1'b0);
    bus.step = 1'b0;
    tick(); check("runstep/T5", 6'b010000, W_T5LDA, 1'b0, 1'b0);
    bus.step = 1'b1;
    tick(); check("runstep/T6", 6'b100000, W_IDLE,  1'b0, 1'b0);
    bus.step = 1'b0;
    tick(); check("runstep/T1", 6'b000001, W_T1,    1'b0, 1'b1);

    // halt: freeze at T5, controls idle whatever the opcode, step ignored
    bus.opcode = HLT;
    tick(); check("hlt/T2", 6'b000010, W_T2,   1'b0, 1'b0);
    tick(); check("hlt/T3", 6'b000100, W_T3,   1'b0, 1'b0);
    tick(); check("hlt/T4", 6'b001000, W_IDLE, 1'b0, 1'b0);
    tick(); check("hlt/T5", 6'b010000, W_IDLE, 1'b1, 1'b0);
    bus.opcode = ADD;
    for (int i = 0; i < 20; i++) begin
      tick(); check("hlt/frozen", 6'b010000, W_IDLE, 1'b1, 1'b0);
    end
    bus.run  = 1'b0;
    bus.step = 1'b1;
    tick(); check("hlt/step_hi", 6'b010000, W_IDLE, 1'b1, 1'b0);
    bus.step = 1'b0;
    tick(); check("hlt/step_lo", 6'b010000, W_IDLE, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check("hlt/rst", 6'b000001, W_IDLE, 1'b0, 1'b0);
    #2 rst = 1'b0;
    tick(); check("hlt/restart", 6'b000001, W_T1, 1'b0, 1'b0);

    // asynchronous abort during T5 of ADD
    bus.run = 1'b1;
    tick(); check("abort/T2", 6'b000010, W_T2,    1'b0, 1'b0);
    tick(); check("abort/T3", 6'b000100, W_T3,    1'b0, 1'b0);
    tick(); check("abort/T4", 6'b001000, W_T4MEM, 1'b0, 1'b0);
    tick(); check("abort/T5", 6'b010000, W_T5AB,  1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 check("abort/now", 6'b000001, W_IDLE, 1'b0, 1'b0);
    tick(); check("abort/held", 6'b000001, W_IDLE, 1'b0, 1'b0);
    rst     = 1'b0;
    bus.run = 1'b0;
    tick(); check("abort/after1", 6'b000001, W_T1, 1'b0, 1'b0);
    tick(); check("abort/after2", 6'b000001, W_T1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sap1_controller.md
SAP1_CONTROLLER -- requirements
Module: sap1_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock), rst input 1 (async, active-high reset).
REQ-002 The block SHALL have these ports:
- opcode  in  4  upper nibble of the instruction register
- run  in  1  1 = free-run, 0 = single-step
- step  in  1  single-step request (level; the rising edge is used)
- t_state  out  6  one-hot ring state; bit0 = T1 ... bit5 = T6
- cp  out  1  PC increment
- ep  out  1  PC drive bus
- lm_n  out  1  MAR load, active-low
- ce_n  out  1  RAM drive bus, active-low (RAM is Hi-Z when 1)
- li_n  out  1  IR load, active-low
- ei_n  out  1  IR address-nibble drive, active-low
- la_n  out  1  A load, active-low
- ea  out  1  A drive bus
- su  out  1  ALU subtract select
- eu  out  1  ALU drive bus
- lb_n  out  1  B load, active-low
- lo_n  out  1  output-register load, active-low
- hlt  out  1  halted flag
- instr_done  out  1  one-cycle instruction-complete pulse
REQ-003 Opcodes SHALL be: LDA=4'b0000, ADD=4'b0001, SUB=4'b0010, OUT=4'b1110, HLT=4'b1111. All others are NOP.

Function
REQ-004 The ring counter SHALL advance T1->T2->...->T6->T1 on a rising clk edge when adv=1.
- adv = !halted & (run | step_rise).
- step_rise = step & !step_q, where step_q is step registered on clk.
REQ-005 When adv=0, t_state SHALL hold its value.
REQ-006 Inactive control word: cp=0, ep=0, lm_n=1, ce_n=1, li_n=1, ei_n=1, la_n=1, ea=0, su=0, eu=0, lb_n=1, lo_n=1. Every signal not listed below SHALL be at its inactive value.
REQ-007 Control outputs SHALL be decoded combinationally from t_state and opcode. The fetch states are the same for all opcodes:
- T1: ep=1, lm_n=0
- T2: cp=1
- T3: ce_n=0, li_n=0
REQ-008 T4 decode:
- LDA/ADD/SUB: ei_n=0, lm_n=0
- OUT: ea=1, lo_n=0
- HLT/NOP: inactive
REQ-009 T5 decode:
- LDA: ce_n=0, la_n=0
- ADD/SUB: ce_n=0, lb_n=0
- others: inactive
REQ-010 T6 decode:
- ADD: eu=1, la_n=0
- SUB: eu=1, su=1, la_n=0
- others: inactive
REQ-011 cp SHALL be active only in T2; a PC increment SHALL occur only on an advancing edge while in T2.
REQ-012 Halt:
- The halted flag SHALL set on the rising edge that leaves T4 with opcode=HLT and adv=1.
- t_state SHALL then be frozen at T5.
- hlt SHALL equal halted.
- While halted=1, all control outputs SHALL be inactive regardless of opcode.
- Only rst clears halted; run and step have no effect while halted.
REQ-013 instr_done SHALL be a registered one-cycle pulse, high during the first cycle in T1 after an advancing edge from T6. It SHALL never assert for HLT.
REQ-014 The opcode input SHALL be ignored during T1-T3 and sampled combinationally during T4-T6. Opcode changes mid-instruction take effect immediately; the IR is required to hold opcode stable.
REQ-015 When run=0, a step held high SHALL produce exactly one advance.
REQ-016 If run and step_rise are both true, the ring SHALL advance once, never twice.
REQ-017 If run falls mid-instruction, the ring SHALL stop in its current T-state and the control word for that state SHALL remain driven.

Reset
REQ-018 rst=1 SHALL immediately force (asynchronously):
- t_state=6'b000001, halted=0, instr_done=0, step_q=0
- all control outputs inactive, including while in T1
REQ-019 After rst deasserts, the T1 control word SHALL be driven from the first clk edge onward.
REQ-020 rst asserted mid-instruction SHALL abort the instruction with no further control pulses.

Verification
REQ-021 run=1, opcode=LDA: T1 ep=1/lm_n=0; T2 cp=1; T3 ce_n=0/li_n=0; T4 ei_n=0/lm_n=0; T5 ce_n=0/la_n=0; T6 inactive; instr_done=1 in the next T1.
REQ-022 run=1, opcode=SUB: T6 drives eu=1, su=1, la_n=0. With ADD, su=0 in T6.
REQ-023 run=1, opcode=OUT: T4 drives ea=1, lo_n=0; T5 and T6 are inactive.
REQ-024 run=1, opcode=HLT: hlt=1 one edge after T4 ends; t_state=6'b010000 is held; all controls stay inactive for 20 cycles; a step pulse has no effect; rst then restores T1 with hlt=0.
REQ-025 run=0, step held high 5 cycles, then low, then high again: exactly two advances (T1->T2->T3). run=1 together with a step edge gives one advance per cycle.
REQ-026 rst pulsed asynchronously (between clk edges) during T5 of ADD: outputs are inactive immediately, t_state=000001, and no la_n/lb_n pulse follows.
